// File: rtl/sub_pkg.sv
// Shared definitions for the nibble-serial subtractor.
// Provides the slice width, the FSM state type and the operand width check.
package sub_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // Operand width must be a non-zero whole number of slices.
  function automatic bit width_ok(input int unsigned w);
    return (w >= SLICE_W) && ((w % SLICE_W) == 0);
  endfunction

endpackage

// File: rtl/borrow_lookahead_slice4.sv
// 4-bit subtract slice with lookahead borrow resolution.
// Ports:
//   a, b : 4-bit minuend / subtrahend slice
//   bin  : borrow into bit 0
//   d    : 4-bit difference a - b - bin
//   bout : borrow out of bit 3
module borrow_lookahead_slice4
  import sub_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               bin,
  output logic [SLICE_W-1:0] d,
  output logic               bout
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   br;

  // Generate: bit borrows on its own; propagate: equal bits pass a borrow through.
  assign g = ~a & b;
  assign p = ~(a ^ b);

  // Each borrow is a flat sum of products over g, p and bin.
  assign br[0] = bin;
  assign br[1] = g[0]
               | (p[0] & bin);
  assign br[2] = g[1]
               | (p[1] & g[0])
               | (p[1] & p[0] & bin);
  assign br[3] = g[2]
               | (p[2] & g[1])
               | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & bin);
  assign br[4] = g[3]
               | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & bin);

  assign d    = a ^ b ^ br[SLICE_W-1:0];
  assign bout = br[SLICE_W];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one 4-bit slice per clock.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : operand handshake (a, b, bin)
//   out_valid/out_ready : result handshake (diff, bout, ovf, zero)
//   bout : unsigned borrow out; ovf : signed overflow; zero : diff == 0
module nibble_serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned N   = WIDTH / SLICE_W;
  localparam int unsigned K_W = (N > 1) ? $clog2(N) : 1;

  if (!width_ok(WIDTH)) begin : g_bad_width
    $fatal(1, "nibble_serial_subtractor: WIDTH must be a positive multiple of 4");
  end

  sub_state_t         state;
  sub_state_t         state_next;
  logic [K_W-1:0]     k;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               borrow_q;
  logic [WIDTH-1:0]   diff_next;
  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_d;
  logic               slice_bout;
  logic               last_slice;
  logic               capture;
  logic               take;

  assign last_slice = (k == K_W'(N - 1));
  assign capture    = (state == IDLE) && in_valid;
  assign take       = (state == DONE) && out_ready;

  // State register; handshake flags follow the next state so they come straight off flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (capture)    state_next = CALC;
      CALC:    if (last_slice) state_next = DONE;
      DONE:    if (take)       state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Current slice taken from the captured operands by index.
  assign slice_a = a_q[SLICE_W*k +: SLICE_W];
  assign slice_b = b_q[SLICE_W*k +: SLICE_W];

  borrow_lookahead_slice4 u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .bin  (borrow_q),
    .d    (slice_d),
    .bout (slice_bout)
  );

  // Difference with the current slice merged in; on the last slice this is the full result.
  always_comb begin
    diff_next = diff;
    diff_next[SLICE_W*k +: SLICE_W] = slice_d;
  end

  // Operand capture, slice stepping and result/flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      k        <= '0;
      diff     <= '0;
      bout     <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
    end else if (capture) begin
      a_q      <= a;
      b_q      <= b;
      borrow_q <= bin;
      k        <= '0;
    end else if (state == CALC) begin
      diff     <= diff_next;
      borrow_q <= slice_bout;
      if (last_slice) begin
        k    <= '0;
        bout <= slice_bout;
        ovf  <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (diff_next[WIDTH-1] ^ a_q[WIDTH-1]);
        zero <= ~|diff_next;
      end else begin
        k <= k + K_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed self-checking bench for nibble_serial_subtractor (WIDTH = 16).
module tb_nibble_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;

  int n_checks = 0;
  int n_fail   = 0;

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present operands and complete the input handshake on the next rising edge.
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic bi);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a        = av;
    b        = bv;
    bin      = bi;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the handshake until out_valid rises, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic run_op(input string name,
                        input logic [15:0] av, input logic [15:0] bv, input logic bi,
                        input logic [15:0] ed, input logic eb, input logic eo, input logic ez);
    int lat;
    start_op(av, bv, bi);
    wait_done(lat);
    check({name, "_latency"}, 32'(lat), 32'd4);
    check({name, "_diff"}, 32'(diff), 32'(ed));
    check({name, "_flags"}, 32'({bout, ovf, zero}), 32'({eb, eo, ez}));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({name, "_idle_after_take"}, 32'({in_ready, out_valid}), 32'b10);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;

    // Reset values
    #12;
    check("reset_outputs", 32'({in_ready, out_valid, diff, bout, ovf, zero}), 32'({1'b1, 1'b0, 16'h0, 3'b000}));
    @(negedge clk);
    rst_n = 1'b1;

    // Basic vectors
    run_op("basic",    16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    run_op("ripple",   16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_op("ovf",      16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    run_op("zero",     16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_op("bin_wrap", 16'h5555, 16'h5555, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_op("neg_ovf",  16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);

    // out_ready held high before out_valid: result taken on the first DONE edge
    start_op(16'h0100, 16'h0001, 1'b1);
    out_ready = 1'b1;
    wait_done(lat);
    check("early_ready_latency", 32'(lat), 32'd4);
    check("early_ready_diff", 32'(diff), 32'h00FE);
    @(posedge clk);
    #1;
    check("early_ready_idle", 32'({in_ready, out_valid}), 32'b10);
    out_ready = 1'b0;

    // Backpressure: hold the result for 10 cycles while in_valid toggles
    start_op(16'hA5A5, 16'h0F0F, 1'b0);
    wait_done(lat);
    check("bp_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      a        = 16'hFFFF;
      b        = 16'h0000;
      @(posedge clk);
      #1;
      check("bp_hold", 32'({in_ready, out_valid, diff, bout, ovf, zero}),
            32'({1'b0, 1'b1, 16'h9696, 3'b000}));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_idle_after_take", 32'({in_ready, out_valid}), 32'b10);
    out_ready = 1'b0;

    // Reset in the middle of CALC (k = 2)
    start_op(16'hFFFF, 16'h1111, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midcalc_reset", 32'({in_ready, out_valid, diff, bout, ovf, zero}),
          32'({1'b1, 1'b0, 16'h0, 3'b000}));
    repeat (2) @(posedge clk);
    #1;
    check("midcalc_reset_held", 32'({in_ready, out_valid, diff}), 32'({1'b1, 1'b0, 16'h0}));
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset", 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
